// File: rtl/motor_pkg.sv
// Shared constants, state encoding and helpers for the motor PWM driver.
package motor_pkg;

    localparam int PWM_FRAME = 127;
    localparam int VEL_W     = 8;

    typedef enum logic {
        RUN       = 1'b0,
        DEAD_TIME = 1'b1
    } state_t;

    // -128 has no positive 8-bit counterpart, so it saturates to full scale.
    function automatic logic [6:0] sat_abs8(input logic [VEL_W-1:0] v);
        if (!v[7])
            return v[6:0];
        else if (v[6:0] == 7'd0)
            return 7'd127;
        else
            return 7'(~v[6:0] + 7'd1);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled tick generator and 127-step PWM frame counter.
module pwm_timebase
    import motor_pkg::*;
#(
    parameter int PRESCALE = 49
) (
    input  logic       cclk,
    input  logic       rstb,
    output logic [6:0] pwm_cnt,
    output logic       tick,
    output logic       frame_end
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PW-1:0] presc;

    assign tick      = (presc == PW'(PRESCALE));
    assign frame_end = tick && (pwm_cnt == 7'(PWM_FRAME - 1));

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= frame_end ? 7'd0 : pwm_cnt + 7'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Sign/magnitude PWM H-bridge driver with frame-aligned updates and
// dead time on every direction reversal.
//   state     | meaning
//   RUN       | bridge driven at duty, direction fixed
//   DEAD_TIME | bridge off for DEAD_PERIODS frames before dir may flip
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PRESCALE     = 49,
    parameter int DEAD_PERIODS = 4
) (
    input  logic             cclk,
    input  logic             rstb,
    input  logic [VEL_W-1:0] velocity,
    output logic             pwm_out,
    output logic             dir,
    output logic             reversing,
    output logic [6:0]       duty
);

    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    state_t        state;
    logic [DW-1:0] dead_cnt;
    logic [6:0]    pwm_cnt;
    logic [6:0]    mag;
    logic          frame_end;
    logic          tick_unused;
    logic          req_sign;
    logic          zero;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .cclk      (cclk),
        .rstb      (rstb),
        .pwm_cnt   (pwm_cnt),
        .tick      (tick_unused),
        .frame_end (frame_end)
    );

    assign req_sign = velocity[VEL_W-1];
    assign mag      = sat_abs8(velocity);
    assign zero     = (mag == 7'd0);

    // pwm_out and reversing are both derived from the pre-edge state, so they
    // switch on the same edge and can never be high together.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state     <= RUN;
            duty      <= '0;
            dir       <= 1'b0;
            dead_cnt  <= '0;
            pwm_out   <= 1'b0;
            reversing <= 1'b0;
        end else begin
            pwm_out   <= (state == RUN) && (pwm_cnt < duty);
            reversing <= (state == DEAD_TIME);
            if (frame_end) begin
                case (state)
                    RUN: begin
                        if (!zero && (req_sign != dir)) begin
                            state    <= DEAD_TIME;
                            duty     <= '0;
                            dead_cnt <= '0;
                        end else begin
                            duty <= mag;
                        end
                    end
                    DEAD_TIME: begin
                        if (dead_cnt == DW'(DEAD_PERIODS - 1)) begin
                            state <= RUN;
                            duty  <= mag;
                            if (!zero)
                                dir <= req_sign;
                        end else begin
                            dead_cnt <= dead_cnt + DW'(1);
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Consumes the signed 8-bit motor velocity command from the velocity generator stage.
- Produces the H-bridge PWM enable and direction signals.
- Converts the command to sign and magnitude, and drives a fixed-frame PWM with a programmable timebase.
- Enforces a dead time on every direction reversal, so DIR never changes while the bridge is driven.
- Single clock domain (cclk); the velocity input is synchronous to cclk.

Parameters:
- PRESCALE, default 49: the PWM tick fires every PRESCALE+1 cclk cycles. At 100 MHz this gives a PWM frame of about 15.7 kHz.
- DEAD_PERIODS, default 4: the number of full PWM frames that the output is held off during a reversal. Must be ≥1.

Ports:
- cclk  in  1: system clock, 100 MHz.
- rstb  in  1: reset, synchronous, active-low.
- velocity  in  8: signed two's-complement velocity command.
- pwm_out  out  1: H-bridge enable (PWM), registered.
- dir  out  1: H-bridge direction; 0 = forward (velocity > 0), 1 = reverse. Registered.
- reversing  out  1: high while in DEAD_TIME state.
- duty  out  7: currently applied duty value, 0..127, for debug.

Behaviour:
- Reset (rstb low at a cclk edge): all outputs and state take these values on the next edge, regardless of current state:
  - presc = 0, pwm_cnt = 0, duty = 0, dir = 0, dead_cnt = 0
  - state = RUN, pwm_out = 0, reversing = 0
- Timebase:
  - presc counts 0..PRESCALE. tick = (presc == PRESCALE); presc wraps to 0 on tick.
  - pwm_cnt counts 0..126 on tick and wraps 126→0. A frame is 127 ticks.
  - frame_end = tick && pwm_cnt == 126.
- Magnitude/sign, combinational from velocity:
  - req_sign = velocity[7].
  - mag = |velocity|, saturated: -128 maps to 127. Result is 7 bits, 0..127.
  - zero = (mag == 0). Zero carries no sign request.
- PWM output:
  - Every cycle, pwm_out <= (state == RUN) && (pwm_cnt < duty).
  - This is one cycle of latency from the counter.
  - duty = 127 gives a continuously high output; duty = 0 gives a continuously low output.
- Duty and direction update only at frame_end; mid-frame velocity changes are ignored (glitch-free PWM).
- State machine (RUN, DEAD_TIME):
  - RUN, at frame_end:
    - If !zero and req_sign != dir: go to DEAD_TIME, duty <= 0, dead_cnt <= 0.
    - Otherwise: duty <= mag, and dir is unchanged.
  - DEAD_TIME:
    - pwm_out = 0 and reversing = 1.
    - At each frame_end: if dead_cnt == DEAD_PERIODS-1, exit; otherwise dead_cnt++.
    - On exit: dir <= req_sign if !zero, else dir is unchanged; duty <= mag; state <= RUN.
    - The velocity sampled at the exit frame_end decides, so a command that returns to the old direction during dead time resumes with the old dir.
- Invariants the bench must check:
  - dir toggles only on the DEAD_TIME exit edge.
  - pwm_out is 0 in the cycle before and the cycle after any dir change.
  - pwm_out is never 1 while reversing = 1.
- Simultaneous events:
  - Reset has priority over everything.
  - A velocity change coincident with frame_end is sampled at that edge.
- Velocity 0 in RUN: duty becomes 0 at the next frame_end, dir is retained, and no dead time is entered.

Decomposition:
- Shared package motor_pkg:
  - PWM_FRAME = 127 and the VEL_W = 8 constant.
  - State enum {RUN, DEAD_TIME}.
  - Saturating-abs function sat_abs8 (signed 8 → unsigned 7).
- One sub-module, pwm_timebase (parameter PRESCALE):
  - Prescaler plus the 0..126 frame counter.
  - Outputs pwm_cnt[6:0], tick and frame_end.
  - Synchronous active-low rstb.

Test Plan (bench overrides PRESCALE=0, DEAD_PERIODS=2, so a frame is 127 cycles):
1. Hold rstb low 3 cycles with velocity = +50 → pwm_out = 0, dir = 0, reversing = 0, duty = 0 throughout reset and until the first frame_end, 127 cycles after release.
2. velocity = +64 steady → after the first frame_end, duty = 64 and pwm_out is high exactly 64 of every 127 cycles; dir = 0 and reversing = 0 throughout.
3. From reset, velocity = -128 →
   - At the first frame_end, reversing = 1 for 254 cycles with pwm_out = 0.
   - Then dir = 1, duty = 127, and pwm_out is continuously high.
4. Steady +127, then velocity = -1 mid-frame →
   - The current frame completes at duty 127.
   - Then reversing = 1 and pwm_out = 0 for 2 frames.
   - Then dir = 1 and pwm_out is high 1 cycle per frame; dir never changes while pwm_out = 1.
5. Steady +20, then velocity = -30 and, during the dead time, back to +20 → after 2 dead frames, dir stays 0 and duty = 20. Also: velocity = 0 in RUN → duty = 0, dir retained, reversing stays 0.
6. Assert rstb for 1 cycle mid-DEAD_TIME (dir = 1 → requesting 0) → next cycle reversing = 0, pwm_out = 0, dir = 0, duty = 0; normal operation resumes from the next frame_end.
